// File: rtl/benes_pkg.sv
// Shared definitions for the Benes looping-algorithm controller.
//   state_e   : controller FSM states
//   idx_width : bit width needed to index n items (never below 1)
package benes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_LOOP  = 3'd3,
        ST_FINAL = 3'd4
    } state_e;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/benes_prio_enc.sv
// Lowest-index priority encoder used to find the next uncovered switch.
//   req_i : one request bit per switch (1 = still uncovered)
//   idx_o : index of the lowest set bit of req_i (0 when none set)
//   any_o : at least one bit of req_i is set
module benes_prio_enc
    import benes_pkg::*;
#(
    parameter  int M  = 4,
    localparam int IW = idx_width(M)
) (
    input  logic [M-1:0]  req_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int k = M - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                idx_o = IW'(k);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/benes_loop_ctrl.sv
// Looping-algorithm controller for the outer stage of an N-port Benes network.
// Given a permutation, it colours the input switches one per cycle, then
// derives the output switches and the two half-size sub-permutations.
//   clk, areset : clock, synchronous active-high reset
//   start, perm : job request and flattened permutation (field i = output of input i)
//   busy, done  : job in progress, one-cycle end-of-job pulse
//   err         : perm was not a bijection (valid with done)
//   sw_in       : input switch s, 1 = cross (input 2s+1 to upper subnet)
//   sw_out      : output switch t, 1 = output 2t fed from lower subnet
//   sub_up/dn   : field s = output-switch index reached from subnet input s
module benes_loop_ctrl
    import benes_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     start,
    input  logic [N*W-1:0]           perm,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [N/2-1:0]           sw_in,
    output logic [N/2-1:0]           sw_out,
    output logic [(N/2)*(W-1)-1:0]   sub_up,
    output logic [(N/2)*(W-1)-1:0]   sub_dn
);

    localparam int H  = N / 2;   // switches per outer stage
    localparam int SW = W - 1;   // switch-index width

    state_e          state_q, state_d;

    // Job tables: captured permutation, its inverse and an output-seen map.
    logic [W-1:0]    perm_q [N];
    logic [W-1:0]    inv_q  [N];
    logic [W-1:0]    inv_d  [N];
    logic [N-1:0]    seen_q, seen_d;

    // Looping state.
    logic [H-1:0]    cover_q, cover_d;
    logic [H-1:0]    sw_work_q;
    logic [W-1:0]    cur_q, cur_d;      // input routed upper this cycle
    logic [SW-1:0]   cur_sw;
    logic [W-1:0]    partner_out;
    logic [W-1:0]    cand;              // input forced lower by the partner output
    logic [SW-1:0]   pe_idx;
    logic            pe_any;

    // Result registers.
    logic            done_q, err_q;
    logic [H-1:0]    sw_in_q, sw_out_q, sw_out_d;
    logic [H*SW-1:0] sub_up_q, sub_up_d, sub_dn_q, sub_dn_d;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_CHECK;
            ST_CHECK: state_d = (&seen_q) ? ST_LOOP : ST_IDLE;
            // One switch is covered per cycle; leave once none remain.
            ST_LOOP:  if (!pe_any) state_d = ST_FINAL;
            ST_FINAL: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------ inverse table
    // A duplicated output leaves some other output unseen, so "all seen"
    // is exactly the bijection test.
    always_comb begin
        seen_d = '0;
        for (int o = 0; o < N; o++) begin
            inv_d[o] = '0;
        end
        for (int i = 0; i < N; i++) begin
            inv_d[perm_q[i]]  = W'(i);
            seen_d[perm_q[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!areset && state_q == ST_IDLE && start) begin
            for (int i = 0; i < N; i++) begin
                perm_q[i] <= perm[i*W +: W];
            end
        end
        if (state_q == ST_LOAD) begin
            inv_q  <= inv_d;
            seen_q <= seen_d;
        end
    end

    // ------------------------------------------------------- looping step
    // Current input cur_q goes upper, so its output's partner must be fed
    // from the lower subnet: the input driving it goes lower and its switch
    // mate goes upper. A closed cycle restarts at the lowest free switch.
    assign cur_sw      = cur_q[W-1:1];
    assign partner_out = perm_q[cur_q] ^ W'(1);
    assign cand        = inv_q[partner_out];
    assign cover_d     = cover_q | (H'(1) << cur_sw);

    benes_prio_enc #(
        .M (H)
    ) u_prio (
        .req_i (~cover_d),
        .idx_o (pe_idx),
        .any_o (pe_any)
    );

    assign cur_d = cover_d[cand[W-1:1]] ? {pe_idx, 1'b0} : (cand ^ W'(1));

    // ---------------------------------------------------- final stage
    for (genvar gi = 0; gi < H; gi++) begin : g_sw
        logic [W-1:0] up_src, dn_src, out_src;
        assign up_src  = {SW'(gi),  sw_work_q[gi]};
        assign dn_src  = {SW'(gi), ~sw_work_q[gi]};
        assign out_src = inv_q[{SW'(gi), 1'b0}];
        assign sub_up_d[gi*SW +: SW] = perm_q[up_src][W-1:1];
        assign sub_dn_d[gi*SW +: SW] = perm_q[dn_src][W-1:1];
        // Source of output 2t is a lower-subnet input when its low bit
        // differs from its switch setting.
        assign sw_out_d[gi] = out_src[0] ^ sw_work_q[out_src[W-1:1]];
    end

    // -------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (areset) begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cover_q   <= '0;
            sw_work_q <= '0;
            cur_q     <= '0;
            sw_in_q   <= '0;
            sw_out_q  <= '0;
            sub_up_q  <= '0;
            sub_dn_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        err_q   <= 1'b0;
                        cover_q <= '0;
                        cur_q   <= '0;
                    end
                end
                ST_CHECK: begin
                    if (!(&seen_q)) begin
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                    end
                end
                ST_LOOP: begin
                    sw_work_q[cur_sw] <= cur_q[0];
                    cover_q           <= cover_d;
                    cur_q             <= cur_d;
                end
                ST_FINAL: begin
                    sw_in_q  <= sw_work_q;
                    sw_out_q <= sw_out_d;
                    sub_up_q <= sub_up_d;
                    sub_dn_q <= sub_dn_d;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign err    = err_q;
    assign sw_in  = sw_in_q;
    assign sw_out = sw_out_q;
    assign sub_up = sub_up_q;
    assign sub_dn = sub_dn_q;

endmodule

// File: tb/tb_benes_loop_ctrl.sv
module tb_benes_loop_ctrl;

    logic clk = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt8 = 0;

    // ---------------------------------------------------------------- N=8
    logic        start8 = 1'b0;
    logic [23:0] perm8  = '0;
    logic        busy8, done8, err8;
    logic [3:0]  swi8, swo8;
    logic [7:0]  up8, dn8;

    benes_loop_ctrl #(.N(8)) u8 (
        .clk(clk), .areset(areset), .start(start8), .perm(perm8),
        .busy(busy8), .done(done8), .err(err8),
        .sw_in(swi8), .sw_out(swo8), .sub_up(up8), .sub_dn(dn8)
    );

    // --------------------------------------------------------------- N=16
    logic         start16 = 1'b0;
    logic [63:0]  perm16  = '0;
    logic         busy16, done16, err16;
    logic [7:0]   swi16, swo16;
    logic [23:0]  up16, dn16;

    benes_loop_ctrl #(.N(16)) u16 (
        .clk(clk), .areset(areset), .start(start16), .perm(perm16),
        .busy(busy16), .done(done16), .err(err16),
        .sw_in(swi16), .sw_out(swo16), .sub_up(up16), .sub_dn(dn16)
    );

    // --------------------------------------------------------------- N=32
    logic         start32 = 1'b0;
    logic [159:0] perm32  = '0;
    logic         busy32, done32, err32;
    logic [15:0]  swi32, swo32;
    logic [63:0]  up32, dn32;

    benes_loop_ctrl #(.N(32)) u32 (
        .clk(clk), .areset(areset), .start(start32), .perm(perm32),
        .busy(busy32), .done(done32), .err(err32),
        .sw_in(swi32), .sw_out(swo32), .sub_up(up32), .sub_dn(dn32)
    );

    // ---------------------------------------------------------- scoreboard
    typedef struct {
        logic       err;
        logic [3:0] swi;
        logic [3:0] swo;
        logic [7:0] up;
        logic [7:0] dn;
        int         lat;
        int         t0;
        string      nm;
    } exp_t;

    exp_t         sb8[$];
    logic [159:0] q16[$];
    logic [159:0] q32[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Pushes a bit through the switch settings and checks it lands at perm[i].
    function automatic int route_errs(input int n, input logic [159:0] p,
                                      input logic [15:0] si, input logic [15:0] so,
                                      input logic [63:0] su, input logic [63:0] sd);
        int w, sw, errs;
        w = $clog2(n);
        sw = w - 1;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            int s, t, o, pi;
            logic up;
            logic [63:0] tsub;
            logic [159:0] tp;
            s = i / 2;
            up = ((i % 2) == int'(si[s]));
            tsub = up ? (su >> (s * sw)) : (sd >> (s * sw));
            t = int'(tsub[15:0]) & ((1 << sw) - 1);
            o = 2 * t + (((up ^ so[t]) == 1'b1) ? 0 : 1);
            tp = p >> (i * w);
            pi = int'(tp[15:0]) & ((1 << w) - 1);
            if (o != pi) errs++;
        end
        return errs;
    endfunction

    function automatic logic [159:0] rand_perm(input int n);
        int a[32];
        int w;
        logic [159:0] p;
        w = $clog2(n);
        for (int i = 0; i < n; i++) a[i] = i;
        for (int i = n - 1; i > 0; i--) begin
            int j, tmp;
            j = int'($urandom_range(i, 0));
            tmp = a[i]; a[i] = a[j]; a[j] = tmp;
        end
        p = '0;
        for (int i = 0; i < n; i++) p = p | (160'(a[i]) << (i * w));
        return p;
    endfunction

    // ------------------------------------------------------------ monitors
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            done_cnt8++;
            if (sb8.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done8: got done=1 expected no job pending");
            end else begin
                exp_t e;
                e = sb8.pop_front();
                chk({e.nm, " err"},     64'(err8),      64'(e.err));
                chk({e.nm, " sw_in"},   64'(swi8),      64'(e.swi));
                chk({e.nm, " sw_out"},  64'(swo8),      64'(e.swo));
                chk({e.nm, " sub_up"},  64'(up8),       64'(e.up));
                chk({e.nm, " sub_dn"},  64'(dn8),       64'(e.dn));
                chk({e.nm, " latency"}, 64'(cyc - e.t0), 64'(e.lat));
                chk({e.nm, " busy"},    64'(busy8),     64'(0));
            end
        end
        if (done16 === 1'b1) begin
            if (q16.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_done16: got done=1 expected no job pending");
            end else begin
                logic [159:0] p;
                p = q16.pop_front();
                chk("r16 err",   64'(err16), 64'(0));
                chk("r16 busy",  64'(busy16), 64'(0));
                chk("r16 route", 64'(route_errs(16, p, 16'(swi16), 16'(swo16),
                                                64'(up16), 64'(dn16))), 64'(0));
            end
        end
        if (done32 === 1'b1) begin
            if (q32.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_done32: got done=1 expected no job pending");
            end else begin
                logic [159:0] p;
                p = q32.pop_front();
                chk("r32 err",   64'(err32), 64'(0));
                chk("r32 busy",  64'(busy32), 64'(0));
                chk("r32 route", 64'(route_errs(32, p, swi32, swo32, up32, dn32)), 64'(0));
            end
        end
    end

    // ----------------------------------------------------------- stimulus
    task automatic issue8(input string nm, input logic [23:0] p, input logic e_err,
                          input logic [3:0] e_si, input logic [3:0] e_so,
                          input logic [7:0] e_up, input logic [7:0] e_dn, input int e_lat);
        exp_t e;
        e.nm = nm; e.err = e_err; e.swi = e_si; e.swo = e_so;
        e.up = e_up; e.dn = e_dn; e.lat = e_lat; e.t0 = cyc;
        sb8.push_back(e);
        perm8  = p;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int w = 0; w < 30 && done8 !== 1'b1; w++) @(negedge clk);
        if (done8 !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL %s timeout: got no done expected done within 30 cycles", nm);
        end
    endtask

    task automatic chk_zero8(input string nm);
        chk({nm, " busy"},   64'(busy8), 64'(0));
        chk({nm, " done"},   64'(done8), 64'(0));
        chk({nm, " err"},    64'(err8),  64'(0));
        chk({nm, " sw_in"},  64'(swi8),  64'(0));
        chk({nm, " sw_out"}, 64'(swo8),  64'(0));
        chk({nm, " sub_up"}, 64'(up8),   64'(0));
        chk({nm, " sub_dn"}, 64'(dn8),   64'(0));
    endtask

    localparam logic [23:0] P_ID  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [23:0] P_REV = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    localparam logic [23:0] P_BAD = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd0, 3'd0};
    // perm = {2,4,0,6,1,3,5,7}
    localparam logic [23:0] P_MIX = {3'd7, 3'd5, 3'd3, 3'd1, 3'd6, 3'd0, 3'd4, 3'd2};

    initial begin
        repeat (3) @(negedge clk);
        chk_zero8("reset");
        areset = 1'b0;
        @(negedge clk);

        issue8("identity", P_ID,  1'b0, 4'h0, 4'h0, 8'hE4, 8'hE4, 8);
        issue8("reverse",  P_REV, 1'b0, 4'h0, 4'hF, 8'h1B, 8'h1B, 8);
        issue8("badperm",  P_BAD, 1'b1, 4'h0, 4'hF, 8'h1B, 8'h1B, 3);
        issue8("mixed",    P_MIX, 1'b0, 4'h2, 4'h5, 8'h8D, 8'hD2, 8);

        // Start held high through the whole job: exactly one job.
        begin
            exp_t e;
            e.nm = "held"; e.err = 1'b0; e.swi = 4'h0; e.swo = 4'h0;
            e.up = 8'hE4; e.dn = 8'hE4; e.lat = 8; e.t0 = cyc;
            sb8.push_back(e);
            perm8  = P_ID;
            start8 = 1'b1;
            repeat (2) @(negedge clk);
            chk("held busy_mid", 64'(busy8), 64'(1));
            repeat (6) @(negedge clk);
            start8 = 1'b0;
            repeat (12) @(negedge clk);
        end

        // Reset while in LOOP: abort without a done pulse.
        perm8  = P_MIX;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        chk_zero8("abort");
        repeat (12) @(negedge clk);
        chk("done_count8", 64'(done_cnt8), 64'(5));
        chk("sb8 drained", 64'(sb8.size()), 64'(0));

        for (int k = 0; k < 1000; k++) begin
            logic [159:0] p;
            p = rand_perm(16);
            q16.push_back(p);
            perm16  = p[63:0];
            start16 = 1'b1;
            @(negedge clk);
            start16 = 1'b0;
            for (int w = 0; w < 40 && done16 !== 1'b1; w++) @(negedge clk);
            if (done16 !== 1'b1) begin
                n_tests++; n_fail++;
                $display("FAIL r16 timeout: got no done expected done within 40 cycles");
            end
        end

        for (int k = 0; k < 1000; k++) begin
            logic [159:0] p;
            p = rand_perm(32);
            q32.push_back(p);
            perm32  = p;
            start32 = 1'b1;
            @(negedge clk);
            start32 = 1'b0;
            for (int w = 0; w < 60 && done32 !== 1'b1; w++) @(negedge clk);
            if (done32 !== 1'b1) begin
                n_tests++; n_fail++;
                $display("FAIL r32 timeout: got no done expected done within 60 cycles");
            end
        end

        repeat (3) @(negedge clk);
        chk("q16 drained", 64'(q16.size()), 64'(0));
        chk("q32 drained", 64'(q32.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #800000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/benes_loop_ctrl.md
BENES_LOOP_CTRL -- requirements
Module: benes_loop_ctrl

Interface
REQ-001 SHALL have parameter N, default 8: port count; power of two, 4..64.
REQ-002 SHALL have parameter W, default $clog2(N): port-index width; not overridden.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port areset  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port start  in  1  request to route the permutation on perm.
REQ-006 SHALL have port perm  in  N*W  flattened permutation; field i = perm[i*W +: W] is the output port for input i.
REQ-007 SHALL have port busy  out  1  high from the accepted start until done.
REQ-008 SHALL have port done  out  1  one-cycle pulse at end of every job.
REQ-009 SHALL have port err  out  1  perm was not a bijection; valid with done, held until next accepted start.
REQ-010 SHALL have port sw_in  out  N/2  input-stage switch s: 1 = cross (input 2s+1 to upper subnet).
REQ-011 SHALL have port sw_out  out  N/2  output-stage switch t: 1 = output 2t is fed from the lower subnet.
REQ-012 SHALL have port sub_up  out  (N/2)*(W-1)  upper sub-permutation; field s = output-switch index reached from upper-subnet input s.
REQ-013 SHALL have port sub_dn  out  (N/2)*(W-1)  lower sub-permutation, same format.

Function
REQ-014 SHALL implement FSM IDLE -> LOAD -> CHECK -> LOOP -> FINAL -> IDLE.
REQ-015 SHALL accept start only in IDLE; perm captured on that edge; start in any other state ignored.
REQ-016 LOAD SHALL build the inverse table inv[o] = i from the captured perm, registered.
REQ-017 CHECK SHALL set err if any output index is missing or duplicated; on err go to IDLE, pulse done, leave sw_in/sw_out/sub_up/sub_dn unchanged.
REQ-018 LOOP SHALL colour exactly one input switch per cycle, N/2 cycles, using a cover table (1 bit per switch).
REQ-019 LOOP first cycle SHALL route input 0 upper (switch 0 straight).
REQ-020 For current upper input c, the next candidate SHALL be j = inv[perm[c]^1] routed lower, hence j^1 upper.
REQ-021 If switch j>>1 is already covered, the next switch SHALL be the lowest-index uncovered switch, with its even input routed upper (straight).
REQ-022 FINAL SHALL compute and register sw_out, sub_up and sub_dn from sw_in and perm in one cycle; sw_in SHALL also update on FINAL only.
REQ-023 Latency: done SHALL be high in the cycle after the (N/2+3)th rising edge following start acceptance (N=8: 7th edge).
REQ-024 busy SHALL be low in IDLE, including the cycle in which done is high.
REQ-025 Result outputs SHALL hold their last values until the next successful FINAL.

Reset
REQ-026 areset SHALL force IDLE and clear busy, done, err, sw_in, sw_out, sub_up, sub_dn and the cover table to 0 on the next edge.
REQ-027 Reset mid-job SHALL abort with no done pulse; start coincident with areset SHALL be ignored.

Structure
REQ-028 A shared package benes_pkg SHALL hold the FSM state enum and the index-width helper function.
REQ-029 Lowest-uncovered-switch search SHALL be one sub-module benes_prio_enc, parameterised by N/2 inputs, outputs index and an any-uncovered flag.

Verification
REQ-030 N=8, perm=identity (0..7) -> err=0, sw_in=0000, sw_out=0000, sub_up=sub_dn={0,1,2,3}.
REQ-031 N=8, perm={7,6,5,4,3,2,1,0} -> sw_in=0000, sw_out=1111, sub_up=sub_dn={3,2,1,0}; done exactly 7 edges after start.
REQ-032 N=8, perm={0,0,2,3,4,5,6,7} -> err=1, done pulses after CHECK, result outputs keep prior values.
REQ-033 Start re-asserted every cycle while busy -> one job only, one done pulse; areset asserted during LOOP -> IDLE, all outputs 0, no done.
REQ-034 N=16 and N=32, 1000 random permutations -> routing through sw_in/sub_up/sub_dn/sw_out reproduces perm, checked by a scoreboard model.
